// File: rtl/mul_ucode_seq.sv
// Microcode multiply sequencer: Rd = Rs * zero_extend(imm) by iterative shift-and-add,
// returning the low DATA_W bits through a register-file write-back handshake.
module mul_ucode_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mul_trigger,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic [REG_AW-1:0] src_reg,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] src_data,
  input  logic              flush,
  input  logic              wb_ready,
  output logic              stall,
  output logic              busy,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(IMM_W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WB
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  mcand;
  logic [IMM_W-1:0]   mplier;
  logic [CNT_W-1:0]   count;
  logic [REG_AW-1:0]  dbg_src_reg;
  logic               unused_dbg;

  logic [DATA_W-1:0]  acc_next;
  logic [IMM_W-1:0]   mplier_next;
  logic               run_last;

  always_comb begin
    acc_next    = acc;
    mplier_next = mplier >> 1;
    run_last    = 1'b0;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
    // Early exit once no multiplier bits remain; count bounds the worst case.
    if ((mplier_next == '0) || (count == CNT_W'(IMM_W - 1))) begin
      run_last = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      count       <= '0;
      wb_valid    <= 1'b0;
      wb_reg      <= '0;
      wb_data     <= '0;
      dbg_src_reg <= '0;
    end else if (flush) begin
      state    <= IDLE;
      wb_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_trigger) begin
            mcand       <= src_data;
            mplier      <= imm;
            wb_reg      <= dest_reg;
            dbg_src_reg <= src_reg;
            acc         <= '0;
            count       <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          count  <= count + CNT_W'(1);
          if (run_last) begin
            wb_valid <= 1'b1;
            wb_data  <= acc_next;
            state    <= WB;
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = (state != IDLE);
  assign busy  = (state != IDLE);

  // done must coincide with the handshake cycle itself, so it is decoded rather
  // than registered; a coincident flush or reset suppresses the write.
  assign done = wb_valid & wb_ready & ~flush & ~rst;

  assign unused_dbg = ^dbg_src_reg;

endmodule

// File: tb/tb_mul_ucode_seq.sv
// Self-checking bench for mul_ucode_seq: directed corner cases plus randomized
// multiplies compared against an arithmetic reference model.
module tb_mul_ucode_seq;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned REG_AW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              mul_trigger;
  logic [REG_AW-1:0] dest_reg;
  logic [REG_AW-1:0] src_reg;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] src_data;
  logic              flush;
  logic              wb_ready;
  logic              stall;
  logic              busy;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              done;

  int checks = 0;
  int errors = 0;

  mul_ucode_seq #(
    .DATA_W(DATA_W),
    .IMM_W (IMM_W),
    .REG_AW(REG_AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mul_trigger(mul_trigger),
    .dest_reg   (dest_reg),
    .src_reg    (src_reg),
    .imm        (imm),
    .src_data   (src_data),
    .flush      (flush),
    .wb_ready   (wb_ready),
    .stall      (stall),
    .busy       (busy),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [15:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[31:0];
  endfunction

  function automatic int ref_cycles(input logic [15:0] b);
    int n;
    n = 1;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) n = i + 1;
    end
    return n;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Full multiply starting in an idle cycle; leaves the bench in the cycle after done.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [15:0] b,
                        input logic [3:0] rd, input int ready_delay, input bit stray);
    logic [31:0] exp_data;
    int n;
    exp_data = ref_prod(a, b);
    n = ref_cycles(b);
    mul_trigger = 1'b1;
    src_data    = a;
    imm         = b;
    dest_reg    = rd;
    src_reg     = ~rd;
    #1;
    check({tag, "_trig_stall"}, 32'(stall), 32'd0);
    tick();
    mul_trigger = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (stray && k == 1) begin
        mul_trigger = 1'b1;
        src_data    = 32'h0BAD_F00D;
        imm         = 16'h7777;
        dest_reg    = rd + 4'd1;
      end
      #1;
      check({tag, "_run_stall"}, 32'(stall), 32'd1);
      check({tag, "_run_wbv"}, 32'(wb_valid), 32'd0);
      tick();
      mul_trigger = 1'b0;
    end
    for (int d = 0; d < ready_delay; d++) begin
      #1;
      check({tag, "_wait_wbv"}, 32'(wb_valid), 32'd1);
      check({tag, "_wait_reg"}, 32'(wb_reg), 32'(rd));
      check({tag, "_wait_data"}, wb_data, exp_data);
      check({tag, "_wait_done"}, 32'(done), 32'd0);
      check({tag, "_wait_stall"}, 32'(stall), 32'd1);
      tick();
    end
    wb_ready = 1'b1;
    #1;
    check({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    check({tag, "_reg"}, 32'(wb_reg), 32'(rd));
    check({tag, "_data"}, wb_data, exp_data);
    check({tag, "_done"}, 32'(done), 32'd1);
    tick();
    wb_ready = 1'b0;
    #1;
    check_idle_outputs({tag, "_after"});
  endtask

  initial begin
    rst         = 1'b1;
    mul_trigger = 1'b0;
    dest_reg    = '0;
    src_reg     = '0;
    imm         = '0;
    src_data    = '0;
    flush       = 1'b0;
    wb_ready    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_idle_outputs("reset");
    check("reset_wb_reg", 32'(wb_reg), 32'd0);
    check("reset_wb_data", wb_data, 32'd0);
    tick();

    do_mul("basic", 32'd7, 16'd6, 4'd3, 0, 1'b0);
    tick();
    do_mul("trunc", 32'hFFFF_FFFF, 16'hFFFF, 4'd9, 0, 1'b0);
    tick();
    do_mul("imm0", 32'h1234, 16'h0000, 4'd1, 0, 1'b0);
    do_mul("imm1", 32'h1234, 16'h0001, 4'd2, 0, 1'b0);
    do_mul("msb", 32'h0000_0003, 16'h8000, 4'd15, 0, 1'b0);
    tick();
    do_mul("bp", 32'd1000, 16'd1000, 4'd5, 3, 1'b0);
    do_mul("stray", 32'd11, 16'h00F3, 4'd6, 1, 1'b1);

    // Flush on the second RUN cycle of a long multiply
    mul_trigger = 1'b1; src_data = 32'd5; imm = 16'hFF00; dest_reg = 4'd4;
    tick();
    mul_trigger = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check_idle_outputs("flush_run");
    for (int k = 0; k < 18; k++) begin
      tick();
      check("flush_run_quiet", 32'(wb_valid), 32'd0);
    end

    // Trigger coinciding with flush is ignored
    mul_trigger = 1'b1; flush = 1'b1; src_data = 32'd3; imm = 16'd3;
    tick();
    mul_trigger = 1'b0; flush = 1'b0;
    #1;
    check_idle_outputs("flush_trig");

    // Flush together with wb_ready in WB drops the write
    mul_trigger = 1'b1; src_data = 32'd9; imm = 16'd1; dest_reg = 4'd7;
    tick();
    mul_trigger = 1'b0;
    tick();
    #1;
    check("flushwb_wbv", 32'(wb_valid), 32'd1);
    wb_ready = 1'b1; flush = 1'b1;
    #1;
    check("flushwb_done", 32'(done), 32'd0);
    tick();
    wb_ready = 1'b0; flush = 1'b0;
    #1;
    check_idle_outputs("flushwb_after");

    // Reset in the middle of RUN clears every output
    mul_trigger = 1'b1; src_data = 32'hDEAD_BEEF; imm = 16'hFFFF; dest_reg = 4'd12;
    tick();
    mul_trigger = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_run");
    check("rst_run_reg", 32'(wb_reg), 32'd0);
    check("rst_run_data", wb_data, 32'd0);
    for (int k = 0; k < 18; k++) begin
      tick();
      check("rst_run_quiet", 32'(wb_valid), 32'd0);
    end

    // Randomized back-to-back multiplies with random backpressure
    for (int r = 0; r < 24; r++) begin
      logic [15:0] rb;
      rb = 16'($urandom);
      if (r % 3 == 0) rb = rb >> $urandom_range(0, 15);
      do_mul("rand", $urandom, rb, 4'($urandom), int'($urandom_range(0, 3)), bit'(r % 5 == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/mul_ucode_seq.md
Name: mul_ucode_seq

Overview:
- Microcode sequencer directly downstream of the instruction decoder; consumes the decoder's multiply trigger (data-immediate opcode 7'b0010000) plus dest register, source register and 16-bit immediate.
- Computes Rd = Rs * zero_extend(imm16) with an iterative shift-and-add sequence and returns the low 32 bits through a register-file write-back handshake.
- Stalls the front end for the whole operation.

Parameters:
- DATA_W, 32, width of register data, multiplicand, accumulator and result.
- IMM_W, 16, width of the immediate multiplier; also the maximum number of RUN cycles.
- REG_AW, 4, register address width.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mul_trigger  input  1  decoder multiply request, single-cycle qualified
- dest_reg  input  REG_AW  destination register (decoder out_destRegister)
- src_reg  input  REG_AW  source register (decoder out_sourceFirstReg); informational, latched for debug
- imm  input  IMM_W  multiplier (decoder out_imm)
- src_data  input  DATA_W  register-file read data for src_reg, valid in the trigger cycle
- flush  input  1  pipeline squash; aborts any operation in flight
- wb_ready  input  1  register-file write port granted
- stall  output  1  high while state != IDLE; holds fetch/decode
- busy  output  1  identical to stall; separate port for the hazard unit
- wb_valid  output  1  write-back request
- wb_reg  output  REG_AW  write-back destination register
- wb_data  output  DATA_W  product, low DATA_W bits
- done  output  1  one-cycle pulse on the cycle the write-back handshake completes

Behaviour:
- Reset values: state=IDLE, acc=0, mcand=0, mplier=0, count=0; stall=0, busy=0, wb_valid=0, wb_reg=0, wb_data=0, done=0.
- Reset taken mid-operation discards everything; no write-back is issued.
- States: IDLE, RUN, WB.
- IDLE, mul_trigger=1 and flush=0:
  - Latch mcand=src_data, mplier=imm, wb_reg=dest_reg, acc=0, count=0.
  - Next state RUN.
  - The trigger cycle itself does not stall; stall rises the following cycle.
- RUN, each cycle:
  - If mplier[0]=1, acc <= acc + mcand (mod 2^DATA_W).
  - mcand <<= 1, truncated to DATA_W.
  - mplier >>= 1.
  - count++.
  - If the shifted mplier is 0, or count reaches IMM_W-1 before increment, go to WB.
- RUN cycle count n = max(1, index of highest set bit of imm + 1):
  - imm=0 or imm=1 gives n=1.
  - imm=0x8000 gives n=16.
- WB:
  - wb_valid=1 and wb_data=acc, both held stable until wb_ready=1.
  - On the wb_valid && wb_ready cycle: done=1, then next state IDLE.
  - wb_valid drops the next cycle.
- Latency: trigger at cycle T, RUN occupies T+1..T+n, wb_valid first asserted at T+n+1, minimum total 2 cycles to write-back.
- mul_trigger while state != IDLE is ignored; the decoder is stalled, so this is an upstream error and not queued.
- flush has priority over every other event:
  - From any state, next state is IDLE with wb_valid=0 and done=0.
  - A wb_ready coinciding with flush does not complete; the write is dropped.
  - A mul_trigger coinciding with flush is ignored.
- No flags are produced. Overflow beyond DATA_W bits is silently truncated.
- Back-to-back multiplies: the cycle after done the block is IDLE and stall=0, so the next trigger is accepted that cycle.

Test Plan:
- Basic multiply: src_data=7, imm=6, dest_reg=3 -> 3 RUN cycles; wb_valid at T+4 with wb_reg=3, wb_data=42; done pulse with wb_ready=1.
- Truncation and maximum latency: src_data=0xFFFFFFFF, imm=0xFFFF -> 16 RUN cycles; wb_data=0xFFFF0001; stall high T+1..T+17.
- Zero and one immediate:
  - imm=0, src_data=0x1234 -> n=1, wb_data=0.
  - imm=1 -> wb_data=0x1234 at T+2.
- Write-back backpressure: wb_ready held low 3 cycles in WB -> wb_valid, wb_reg and wb_data stable throughout; done only in the cycle wb_ready=1; IDLE the cycle after.
- Flush and reset:
  - flush asserted at RUN cycle 2 of imm=0xFF00 -> IDLE next cycle, no wb_valid.
  - flush with wb_ready in WB -> no done.
  - rst mid-RUN -> all outputs 0 next cycle.
- Ignored and back-to-back triggers:
  - mul_trigger pulsed during RUN -> no effect on result.
  - New trigger in the cycle after done -> accepted; second result correct.
